// File: rtl/mux_sel_serializer.sv
// mux_sel_serializer: holds a word on the 8:1 mux data lines and walks
// the select through all eight positions, one bit per downstream transfer.
module mux_sel_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] data_in,
  output logic [7:0] i_out,
  output logic [2:0] s_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       bit_out,
  output logic       done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [2:0] CNT_FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] CNT_LAST  = MSB_FIRST ? 3'd0 : 3'd7;

  state_t     state_q, state_d;
  logic [7:0] word_q,  word_d;
  logic [2:0] cnt_q,   cnt_d;
  logic       done_q,  done_d;

  logic last_bit;
  logic bit_fire;
  logic load_fire;

  // Mirror of the external mux so bit_out can be compared against y.
  function automatic logic mux8(input logic [7:0] i, input logic [2:0] s);
    return i[s];
  endfunction

  assign last_bit   = (cnt_q == CNT_LAST);
  assign bit_valid  = (state_q == SEND);
  assign bit_fire   = bit_valid & bit_ready;
  assign load_ready = (state_q == IDLE) | (bit_fire & last_bit);
  assign load_fire  = load_valid & load_ready;

  assign i_out   = word_q;
  assign s_out   = cnt_q;
  assign bit_out = mux8(word_q, cnt_q);
  assign done    = done_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_fire) begin
          word_d  = data_in;
          cnt_d   = CNT_FIRST;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bit_fire) begin
          if (last_bit) begin
            done_d = 1'b1;
            if (load_fire) begin
              word_d  = data_in;
              cnt_d   = CNT_FIRST;
            end else begin
              state_d = IDLE;
            end
          end else if (MSB_FIRST) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= 8'h00;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/mux_sel_serializer.md
Name: mux_sel_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the 8:1 multiplexer, mux_8x1 (data i[7:0], select s[2:0], output y). It accepts an 8-bit word through a valid/ready handshake and holds it on the mux data lines. It then steps the 3-bit select through all eight positions, one bit per accepted downstream transfer, producing a framed serial bit stream. An internal mirror of the mux function drives bit_out, so the block is self-checking against the external mux.

Parameters:
- MSB_FIRST, default 0: 0 = select counts 0→7 (LSB first); 1 = select counts 7→0 (MSB first).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- load_valid  input  1  upstream word available on data_in
- load_ready  output  1  block can accept a word this cycle
- data_in  input  8  word to serialize
- i_out  output  8  held word, wired to mux i[7:0]
- s_out  output  3  current select, wired to mux s[2:0]
- bit_valid  output  1  bit_out carries a frame bit
- bit_ready  input  1  downstream consumes bit_out this cycle
- bit_out  output  1  equals i_out[s_out]; must match mux y
- done  output  1  one-cycle pulse on the clock after the last bit of a frame is consumed

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; rst is sampled only at rising clk.
- Reset values:
  - state = IDLE
  - word register = 8'h00, so i_out = 0
  - select counter = 0, so s_out = 0
  - bit_valid = 0, bit_out = 0, done = 0
  - load_ready = 1 on the first cycle after reset.
- States: IDLE, SEND.
- Load fire: load_valid & load_ready.
  - word ← data_in.
  - cnt ← 0 when MSB_FIRST = 0; cnt ← 7 when MSB_FIRST = 1.
  - state ← SEND.
  - Latency: fire at edge N, first bit valid in cycle N+1.
- bit_valid = (state == SEND). bit_out is combinational word[cnt]. s_out = cnt. i_out = word.
- Bit fire: bit_valid & bit_ready.
  - Not last bit: cnt steps +1 (LSB-first) or −1 (MSB-first).
  - Last bit is cnt == 7 (LSB-first) or cnt == 0 (MSB-first).
- Without a bit fire, all outputs hold: stall of any length, no bit lost or repeated.
- Last bit fire:
  - done = 1 in the following cycle for exactly one cycle.
  - If load also fires that cycle, the new word loads and the state stays SEND (gapless stream).
  - Otherwise the state goes to IDLE. The word register and cnt hold their last values; s_out is not reset.
- load_ready = (state == IDLE) | (state == SEND & bit_ready & last bit). Combinational; no combinational path from load_valid to load_ready.
- Outside a load fire, data_in and load_valid are ignored. A word offered during SEND (not on the last-bit fire) stays pending at the source.
- The counter never wraps mid-frame. Exactly 8 bit fires per frame.
- rst during SEND aborts the frame: no done pulse, all outputs return to reset values on the next cycle.
- rst has priority over a simultaneous load or bit fire.
- done in the same cycle as bit_valid is legal only in the gapless case.

Test Plan:
1. Reset, MSB_FIRST=0; load 8'hA5 with bit_ready held high → bit_out 1,0,1,0,0,1,0,1 on 8 consecutive bit_valid cycles, s_out 0..7, done pulse on cycle 9, load_ready high after.
2. MSB_FIRST=1; load 8'h3C → bits 0,0,1,1,1,1,0,0 with s_out 7..0, then a single done pulse; every cycle, bit_out == mux_8x1 y for the same i/s.
3. Load 8'h96; drop bit_ready for 3 cycles after the 2nd bit → s_out and bit_out hold for 3 cycles, the sequence resumes, total 8 bits = 0,1,1,0,1,0,0,1, done 1 cycle after the 8th fire.
4. Gapless: load_valid held high with 8'hFF then 8'h00 → 16 consecutive bit_valid cycles (8 ones, then 8 zeros), load_ready high only on the 8th-bit cycle, done pulses after bits 8 and 16.
5. Load 8'hF0; assert load_valid with 8'h0F at bit 3 → ignored, the frame completes as 0,0,0,0,1,1,1,1.
6. Load 8'hAA; assert rst after the 4th bit → next cycle bit_valid = 0, s_out = 0, i_out = 0, no done pulse; a new load of 8'h01 then serializes correctly.
